// File: rtl/hdr_cmd_scheduler_pkg.sv
// Shared types and constants for the HDR-DDR command scheduler.
package hdr_cmd_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RUN_CCC,
    ST_RUN_DDR,
    ST_RESTART,
    ST_EXIT,
    ST_DONE
  } sched_state_e;

  // Descriptor field positions
  localparam int TOC_BIT  = 15;
  localparam int CP_BIT   = 14;
  localparam int MODE_MSB = 13;
  localparam int MODE_LSB = 11;
  localparam int TID_MSB  = 10;
  localparam int TID_LSB  = 7;

  localparam logic [2:0] MODE_HDR_DDR = 3'd6;

  // Response error codes
  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_BAD_MODE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_EMPTY    = 2'd3;

endpackage

// File: rtl/hdr_sched_watchdog.sv
// Saturating wait-state watchdog; expired once the count reaches TIMEOUT_CYCLES-1.
module hdr_sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMR_W          = 13
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                    cnt_d = '0;
    else if (i_en && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/hdr_cmd_scheduler.sv
// HDR-DDR command scheduler: pops descriptors, runs CCC/DDR blocks,
// requests restart/exit patterns and reports responses and completion.
module hdr_cmd_scheduler
  import hdr_cmd_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMR_W          = 13
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_sched_en,
  input  logic        i_cmdq_valid,
  input  logic [15:0] i_cmdq_desc,
  output logic        o_cmdq_ready,
  output logic        o_ccc_en,
  input  logic        i_ccc_done,
  output logic        o_ddr_en,
  input  logic        i_ddr_done,
  output logic        o_restart_en,
  output logic        o_exit_en,
  input  logic        i_pattern_done,
  output logic        o_resp_valid,
  output logic [3:0]  o_resp_tid,
  output logic [1:0]  o_resp_err,
  output logic        o_sched_done
);

  sched_state_e state_q, state_d;
  logic [15:0]  desc_q, desc_d;
  logic         armed_q, armed_d;
  logic         cmdq_ready_q, cmdq_ready_d;
  logic         resp_valid_q, resp_valid_d;
  logic [3:0]   resp_tid_q, resp_tid_d;
  logic [1:0]   resp_err_q, resp_err_d;
  logic         wd_en, wd_clr, wd_expired;

  // Only TOC and TID are needed once a descriptor has been latched
  logic unused_desc;
  assign unused_desc = ^{desc_q[14:11], desc_q[6:0], i_cmdq_desc[6:0]};

  hdr_sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_watchdog (
    .i_sys_clk  (i_sys_clk),
    .i_sys_rst_n(i_sys_rst_n),
    .i_clr      (wd_clr),
    .i_en       (wd_en),
    .o_expired  (wd_expired)
  );

  // Watchdog runs in every wait state; FETCH only while the queue is empty
  always_comb begin
    wd_en = 1'b0;
    case (state_q)
      ST_FETCH:                                   wd_en = !i_cmdq_valid;
      ST_RUN_CCC, ST_RUN_DDR, ST_RESTART, ST_EXIT: wd_en = 1'b1;
      default:                                    wd_en = 1'b0;
    endcase
  end

  assign wd_clr = (state_d != state_q);

  // Next-state and registered-output logic; abort overrides everything
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    desc_d       = desc_q;
    armed_d      = armed_q;
    cmdq_ready_d = 1'b0;
    resp_valid_d = 1'b0;
    resp_tid_d   = 4'd0;
    resp_err_d   = ERR_OK;

    case (state_q)
      ST_IDLE: if (armed_q) begin
        state_d = ST_FETCH;
        desc_d  = '0;  // nothing latched yet in this sequence
      end
      ST_FETCH: begin
        if (i_cmdq_valid && !cmdq_ready_q) begin
          cmdq_ready_d = 1'b1;
          desc_d       = i_cmdq_desc;
          if (i_cmdq_desc[MODE_MSB:MODE_LSB] != MODE_HDR_DDR) begin
            state_d      = ST_EXIT;
            resp_valid_d = 1'b1;
            resp_tid_d   = i_cmdq_desc[TID_MSB:TID_LSB];
            resp_err_d   = ERR_BAD_MODE;
          end else begin
            state_d = i_cmdq_desc[CP_BIT] ? ST_RUN_CCC : ST_RUN_DDR;
          end
        end else if (!i_cmdq_valid && wd_expired) begin
          state_d      = ST_EXIT;
          resp_valid_d = 1'b1;
          resp_tid_d   = desc_q[TID_MSB:TID_LSB];
          resp_err_d   = ERR_EMPTY;
        end
      end
      ST_RUN_CCC, ST_RUN_DDR: begin
        // Only the done of the block owning this state counts; done beats expiry
        if ((state_q == ST_RUN_CCC) ? i_ccc_done : i_ddr_done) begin
          state_d      = desc_q[TOC_BIT] ? ST_EXIT : ST_RESTART;
          resp_valid_d = 1'b1;
          resp_tid_d   = desc_q[TID_MSB:TID_LSB];
          resp_err_d   = ERR_OK;
        end else if (wd_expired) begin
          state_d      = ST_EXIT;
          resp_valid_d = 1'b1;
          resp_tid_d   = desc_q[TID_MSB:TID_LSB];
          resp_err_d   = ERR_TIMEOUT;
        end
      end
      ST_RESTART: begin
        if (i_pattern_done) begin
          state_d = ST_FETCH;
        end else if (wd_expired) begin
          state_d      = ST_EXIT;
          resp_valid_d = 1'b1;
          resp_tid_d   = desc_q[TID_MSB:TID_LSB];
          resp_err_d   = ERR_TIMEOUT;
        end
      end
      ST_EXIT: if (i_pattern_done || wd_expired) state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        armed_d = 1'b0;  // wait for the engine to drop the enable
      end
      default: state_d = ST_IDLE;
    endcase

    if (!i_sched_en) begin
      state_d      = ST_IDLE;
      armed_d      = 1'b1;
      cmdq_ready_d = 1'b0;
      resp_valid_d = 1'b0;
      resp_tid_d   = 4'd0;
      resp_err_d   = ERR_OK;
    end
  end

  // State and output registers; enables follow the next state so they
  // change in the same cycle as the state
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q      <= ST_IDLE;
      desc_q       <= '0;
      armed_q      <= 1'b1;
      cmdq_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_tid_q   <= 4'd0;
      resp_err_q   <= ERR_OK;
      o_ccc_en     <= 1'b0;
      o_ddr_en     <= 1'b0;
      o_restart_en <= 1'b0;
      o_exit_en    <= 1'b0;
      o_sched_done <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      desc_q       <= desc_d;
      armed_q      <= armed_d;
      cmdq_ready_q <= cmdq_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_tid_q   <= resp_tid_d;
      resp_err_q   <= resp_err_d;
      o_ccc_en     <= (state_d == ST_RUN_CCC);
      o_ddr_en     <= (state_d == ST_RUN_DDR);
      o_restart_en <= (state_d == ST_RESTART);
      o_exit_en    <= (state_d == ST_EXIT);
      o_sched_done <= (state_d == ST_DONE);
    end
  end

  assign o_cmdq_ready = cmdq_ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_tid   = resp_tid_q;
  assign o_resp_err   = resp_err_q;

endmodule

// File: tb/tb_hdr_cmd_scheduler.sv
// Directed self-checking bench for hdr_cmd_scheduler (watchdog shortened to 64).
module tb_hdr_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sched_en, cmdq_valid, ccc_done, ddr_done, pattern_done;
  logic [15:0] desc;
  logic        o_cmdq_ready, o_ccc_en, o_ddr_en, o_restart_en, o_exit_en;
  logic        o_resp_valid, o_sched_done;
  logic [3:0]  o_resp_tid;
  logic [1:0]  o_resp_err;

  int total = 0;
  int bad   = 0;
  int pop_cnt = 0, resp_cnt = 0, done_cnt = 0;
  int pop0, resp0, done0;

  always #5 clk = ~clk;

  hdr_cmd_scheduler #(.TIMEOUT_CYCLES(64), .TMR_W(7)) dut (
    .i_sys_clk     (clk),
    .i_sys_rst_n   (rst_n),
    .i_sched_en    (sched_en),
    .i_cmdq_valid  (cmdq_valid),
    .i_cmdq_desc   (desc),
    .o_cmdq_ready  (o_cmdq_ready),
    .o_ccc_en      (o_ccc_en),
    .i_ccc_done    (ccc_done),
    .o_ddr_en      (o_ddr_en),
    .i_ddr_done    (ddr_done),
    .o_restart_en  (o_restart_en),
    .o_exit_en     (o_exit_en),
    .i_pattern_done(pattern_done),
    .o_resp_valid  (o_resp_valid),
    .o_resp_tid    (o_resp_tid),
    .o_resp_err    (o_resp_err),
    .o_sched_done  (o_sched_done)
  );

  // Pulse counters
  always @(posedge clk) begin
    if (o_cmdq_ready) pop_cnt  <= pop_cnt + 1;
    if (o_resp_valid) resp_cnt <= resp_cnt + 1;
    if (o_sched_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [15:0] mk(input logic toc, input logic cp,
                                     input logic [2:0] mode, input logic [3:0] tid);
    return {toc, cp, mode, tid, 7'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Response bundle {valid, tid, err}
  function automatic logic [6:0] resp();
    return {o_resp_valid, o_resp_tid, o_resp_err};
  endfunction

  initial begin
    rst_n = 1'b0; sched_en = 1'b0; cmdq_valid = 1'b0; desc = '0;
    ccc_done = 1'b0; ddr_done = 1'b0; pattern_done = 1'b0;
    #12;
    check("reset_outputs", {o_cmdq_ready, o_ccc_en, o_ddr_en, o_restart_en, o_exit_en,
                            o_resp_valid, o_resp_tid, o_resp_err, o_sched_done}, 0);
    rst_n = 1'b1;
    tick(2);

    // ---- Single CCC command: CP=1 TOC=1 TID=3, done after 20 cycles
    pop0 = pop_cnt;
    desc = mk(1, 1, 3'd6, 4'd3); cmdq_valid = 1'b1; sched_en = 1'b1;
    tick(2);
    check("s1_pop", o_cmdq_ready, 1);
    check("s1_ccc_en_rise", o_ccc_en, 1);
    cmdq_valid = 1'b0;
    tick();
    check("s1_pop_once", o_cmdq_ready, 0);
    tick(18);
    check("s1_ccc_en_cycle20", o_ccc_en, 1);
    ccc_done = 1'b1;
    tick();
    ccc_done = 1'b0;
    check("s1_ccc_en_drop", o_ccc_en, 0);
    check("s1_resp", resp(), {1'b1, 4'd3, 2'd0});
    check("s1_exit_en", o_exit_en, 1);
    tick();
    check("s1_resp_one_cycle", o_resp_valid, 0);
    check("s1_exit_held", o_exit_en, 1);
    pattern_done = 1'b1;
    tick();
    pattern_done = 1'b0;
    check("s1_sched_done", {o_exit_en, o_sched_done}, 2'b01);
    tick();
    check("s1_done_one_pulse", o_sched_done, 0);
    cmdq_valid = 1'b1;  // enable still high: must not re-arm
    tick(3);
    check("s1_no_rearm", {o_cmdq_ready, o_ccc_en}, 0);
    check("s1_pop_count", pop_cnt - pop0, 1);
    sched_en = 1'b0; cmdq_valid = 1'b0;
    tick();

    // ---- Two-command chain: DDR TID=1 TOC=0, then CCC TID=2 TOC=1
    pop0 = pop_cnt; resp0 = resp_cnt;
    desc = mk(0, 0, 3'd6, 4'd1); cmdq_valid = 1'b1; sched_en = 1'b1;
    tick(2);
    check("s2_ddr_en", {o_ddr_en, o_ccc_en}, 2'b10);
    desc = mk(1, 1, 3'd6, 4'd2);
    tick(4);
    ddr_done = 1'b1;
    tick();
    ddr_done = 1'b0;
    check("s2_resp1", resp(), {1'b1, 4'd1, 2'd0});
    check("s2_restart", {o_ddr_en, o_restart_en}, 2'b01);
    tick(2);
    pattern_done = 1'b1;
    tick();
    pattern_done = 1'b0;
    check("s2_restart_drop", o_restart_en, 0);
    tick();
    check("s2_pop2_ccc_en", {o_cmdq_ready, o_ccc_en}, 2'b11);
    cmdq_valid = 1'b0;
    ddr_done = 1'b1;  // wrong block's done: ignored
    tick();
    ddr_done = 1'b0;
    check("s2_ignore_ddr_done", {o_ccc_en, o_resp_valid}, 2'b10);
    ccc_done = 1'b1; ddr_done = 1'b1;
    tick();
    ccc_done = 1'b0; ddr_done = 1'b0;
    check("s2_resp2", resp(), {1'b1, 4'd2, 2'd0});
    check("s2_exit_en", o_exit_en, 1);
    pattern_done = 1'b1;
    tick();
    pattern_done = 1'b0;
    check("s2_sched_done", o_sched_done, 1);
    check("s2_pop_count", pop_cnt - pop0, 2);
    check("s2_resp_count", resp_cnt - resp0, 2);
    sched_en = 1'b0;
    tick();

    // ---- Bad MODE=3, TID=5
    desc = mk(1, 1, 3'd3, 4'd5); cmdq_valid = 1'b1; sched_en = 1'b1;
    tick(2);
    cmdq_valid = 1'b0;
    check("s3_resp_bad_mode", resp(), {1'b1, 4'd5, 2'd1});
    check("s3_no_enables_exit", {o_ccc_en, o_ddr_en, o_exit_en}, 3'b001);
    tick();
    pattern_done = 1'b1;
    tick();
    pattern_done = 1'b0;
    check("s3_sched_done", o_sched_done, 1);
    sched_en = 1'b0;
    tick();

    // ---- DDR timeout (TID=7), then EXIT watchdog with no pattern_done
    desc = mk(1, 0, 3'd6, 4'd7); cmdq_valid = 1'b1; sched_en = 1'b1;
    tick(2);
    cmdq_valid = 1'b0;
    check("s4_ddr_en_rise", o_ddr_en, 1);
    tick(63);
    check("s4_ddr_en_cycle64", {o_ddr_en, o_resp_valid}, 2'b10);
    tick();
    check("s4_ddr_en_drop", o_ddr_en, 0);
    check("s4_resp_timeout", resp(), {1'b1, 4'd7, 2'd2});
    check("s4_exit_en", o_exit_en, 1);
    tick(63);
    check("s4_exit_wait", {o_exit_en, o_sched_done}, 2'b10);
    tick();
    check("s4_exit_timeout_done", {o_exit_en, o_sched_done}, 2'b01);
    sched_en = 1'b0;
    tick();

    // ---- Empty queue after TOC=0 (TID=4)
    desc = mk(0, 1, 3'd6, 4'd4); cmdq_valid = 1'b1; sched_en = 1'b1;
    tick(2);
    cmdq_valid = 1'b0;
    tick();
    ccc_done = 1'b1;
    tick();
    ccc_done = 1'b0;
    check("s5_restart", o_restart_en, 1);
    pattern_done = 1'b1;
    tick();
    pattern_done = 1'b0;
    tick(63);
    check("s5_still_fetch", {o_resp_valid, o_exit_en, o_cmdq_ready}, 0);
    tick();
    check("s5_resp_empty", resp(), {1'b1, 4'd4, 2'd3});
    check("s5_exit_en", o_exit_en, 1);
    pattern_done = 1'b1;
    tick();
    pattern_done = 1'b0;
    check("s5_sched_done", o_sched_done, 1);
    sched_en = 1'b0;
    tick();

    // ---- Abort during RUN_CCC, done arriving the same cycle
    desc = mk(1, 1, 3'd6, 4'd9); cmdq_valid = 1'b1; sched_en = 1'b1;
    tick(2);
    cmdq_valid = 1'b0;
    tick(2);
    resp0 = resp_cnt; done0 = done_cnt;
    sched_en = 1'b0; ccc_done = 1'b1;
    tick();
    ccc_done = 1'b0;
    check("s6_abort_ccc_en", {o_ccc_en, o_resp_valid, o_exit_en}, 0);
    tick(3);
    check("s6_abort_no_resp", resp_cnt - resp0, 0);
    check("s6_abort_no_done", done_cnt - done0, 0);

    // ---- Async reset mid-RESTART
    desc = mk(0, 0, 3'd6, 4'd2); cmdq_valid = 1'b1; sched_en = 1'b1;
    tick(2);
    cmdq_valid = 1'b0;
    ddr_done = 1'b1;
    tick();
    ddr_done = 1'b0;
    check("s7_restart_en", o_restart_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s7_async_reset", {o_cmdq_ready, o_ccc_en, o_ddr_en, o_restart_en, o_exit_en,
                             o_resp_valid, o_resp_tid, o_resp_err, o_sched_done}, 0);
    sched_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdr_cmd_scheduler.md
Name: hdr_cmd_scheduler

Overview:
- Sequences HDR-DDR transfers for the I3C controller.
- Pops command descriptors from the command queue and enables the CCC block or the DDR-mode block for each one.
- After each command it triggers the HDR restart or exit pattern generator, then reports per-command responses and overall completion to the I3C engine.
- Sits between the I3C engine, the command queue, the CCC/DDR blocks and the pattern generator.

Parameters:
- TIMEOUT_CYCLES, 4096: watchdog limit for any wait state (cycles).
- TMR_W, 13: watchdog counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst_n  in  1  asynchronous active-low reset.
- i_sched_en  in  1  level enable from the I3C engine; low aborts the sequence.
- i_cmdq_valid  in  1  queue head is valid.
- i_cmdq_desc  in  16  descriptor fields: [15] TOC, [14] CP, [13:11] MODE, [10:7] TID, [6:0] reserved.
- o_cmdq_ready  out  1  one-cycle pop strobe.
- o_ccc_en  out  1  level enable to the CCC block.
- i_ccc_done  in  1  CCC block done pulse.
- o_ddr_en  out  1  level enable to the DDR-mode block.
- i_ddr_done  in  1  DDR-mode block done pulse.
- o_restart_en  out  1  request an HDR restart pattern.
- o_exit_en  out  1  request an HDR exit pattern.
- i_pattern_done  in  1  pattern generator done pulse.
- o_resp_valid  out  1  one-cycle response strobe.
- o_resp_tid  out  4  TID of the completed command.
- o_resp_err  out  2  error code: 0 ok, 1 bad MODE, 2 timeout, 3 queue empty.
- o_sched_done  out  1  one-cycle completion pulse to the I3C engine.

Behaviour:
- Reset: all outputs 0; state IDLE; latched descriptor 0; watchdog 0.
- States: IDLE, FETCH, RUN_CCC, RUN_DDR, RESTART, EXIT, DONE. All outputs are registered.
- IDLE: when i_sched_en=1, go to FETCH next cycle.
- FETCH:
  - The watchdog counts while i_cmdq_valid=0.
  - When valid: latch the descriptor and pulse o_cmdq_ready once (never in two consecutive cycles).
  - MODE!=6: set err=1, go to EXIT.
  - Otherwise CP=1 goes to RUN_CCC, CP=0 goes to RUN_DDR. The matching enable rises in the same cycle as the state change.
  - Watchdog reaching TIMEOUT_CYCLES-1 with the queue still empty: err=3, go to EXIT.
- RUN_CCC / RUN_DDR:
  - Hold the enable high and ignore the other block's done.
  - On the matching done: drop the enable next cycle; pulse o_resp_valid with TID and err=0.
  - Then TOC=1 goes to EXIT, TOC=0 goes to RESTART.
  - Watchdog expiry: drop the enable, response with err=2, go to EXIT.
- RESTART: hold o_restart_en until i_pattern_done, then go to FETCH. This leg is also watchdog protected; on expiry go to EXIT with err=2.
- EXIT: hold o_exit_en until i_pattern_done, then go to DONE. If the watchdog expires, go to DONE anyway.
- Error paths: responses for error paths are issued on entry to EXIT, carrying the latched TID, or 0 if none was latched.
- DONE: pulse o_sched_done for one cycle, go to IDLE. The scheduler does not re-arm until i_sched_en has been seen low for at least one cycle.
- Watchdog: clears on every state change; it is a saturating counter of TMR_W bits.
- Minimum latency: descriptor accepted to enable high is 1 cycle; done to restart_en high is 1 cycle.
- Abort: i_sched_en low in any state → next cycle IDLE, all enables 0, no response, no o_sched_done.
- Simultaneous done and watchdog expiry in the same cycle: done wins (err=0).
- Simultaneous i_ccc_done and i_ddr_done: only the one matching the current state counts.
- Reset mid-operation: immediate return to reset values; any in-flight command is lost and is the I3C engine's to recover.

Decomposition:
- Shared package holds:
  - state encodings;
  - descriptor field bit positions (TOC, CP, MODE, TID);
  - MODE_HDR_DDR=3'd6;
  - the error-code constants.
- One natural sub-module is hdr_sched_watchdog: the saturating counter, with clear, enable and expired outputs, parameterised by TIMEOUT_CYCLES/TMR_W. The FSM stays in the top module.

Test Plan:
- Single CCC command: desc CP=1, TOC=1, MODE=6, TID=3; ccc_done after 20 cycles, then pattern_done → ccc_en high 20 cycles; resp TID=3, err=0; exit_en; o_sched_done one pulse.
- Two-command chain: DDR (TOC=0, TID=1) then CCC (TOC=1, TID=2) → ddr_en, resp 1, restart_en, pop, ccc_en, resp 2, exit_en, done. Exactly 2 o_cmdq_ready pulses.
- Bad mode: desc MODE=3, TID=5 → no ccc_en/ddr_en; resp err=1, TID=5; exit_en; done.
- Timeout: DDR command, ddr_done never asserted, TIMEOUT_CYCLES=64 → ddr_en drops at cycle 64; resp err=2; exit_en.
- Empty queue after TOC=0: valid stays low 64 cycles → resp err=3, exit, done.
- Abort and reset: i_sched_en low during RUN_CCC → ccc_en=0 next cycle, no resp, no done. Async reset mid-RESTART → all outputs 0 immediately.
